// File: rtl/mult_sched_pkg.sv
// Shared definitions for the multiplier scheduler: state encoding,
// default sizing and small helpers used by the top and its picker.
package mult_sched_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_TIMEOUT = 64;
    localparam int GNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [7:0] onehot8(input logic [GNT_W-1:0] idx);
        onehot8 = 8'd1 << idx;
    endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Client request/response bus plus the shared-multiplier port, bundled so the
// scheduler and its environment connect through one handle.
interface mult_sched_if
    import mult_sched_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) ();

    logic [N-1:0]     req;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     ack;
    logic [2*W-1:0]   rsp_data;
    logic             rsp_err;
    logic             busy;
    logic [GNT_W-1:0] gnt_id;
    logic             mul_st;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_result;
    logic             mul_done;

    modport master (
        output req, req_a, req_b, mul_result, mul_done,
        input  ack, rsp_data, rsp_err, busy, gnt_id, mul_st, mul_a, mul_b
    );

    modport slave (
        input  req, req_a, req_b, mul_result, mul_done,
        output ack, rsp_data, rsp_err, busy, gnt_id, mul_st, mul_a, mul_b
    );

endinterface

// File: rtl/mult_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward and wrapping modulo N.
module rr_pick
    import mult_sched_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]     req_i,
    input  logic [GNT_W-1:0] ptr_i,
    output logic             any_o,
    output logic [GNT_W-1:0] idx_o
);

    logic [7:0] req_pad_s;
    logic [3:0] sum_s;
    logic [3:0] cand_s;
    logic       hit_s;

    // Walk the candidates in priority order; the first hit is kept.
    always_comb begin
        req_pad_s = 8'(req_i);
        any_o     = 1'b0;
        idx_o     = '0;
        sum_s     = 4'd0;
        cand_s    = 4'd0;
        hit_s     = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum_s  = {1'b0, ptr_i} + 4'(i);
            cand_s = (sum_s >= 4'(N)) ? (sum_s - 4'(N)) : sum_s;
            hit_s  = !any_o && req_pad_s[cand_s[2:0]];
            idx_o  = hit_s ? cand_s[2:0] : idx_o;
            any_o  = any_o | hit_s;
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one multiplier among N clients: grant,
// start pulse, watchdog-guarded wait for done, one-cycle ack with the product.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst_n,
    mult_sched_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_e           state_q;
    logic [GNT_W-1:0] ptr_q;
    logic [GNT_W-1:0] gnt_q;
    logic [CW-1:0]    cnt_q;
    logic [N-1:0]     ack_q;
    logic [2*W-1:0]   rsp_data_q;
    logic             rsp_err_q;
    logic             busy_q;
    logic             mul_st_q;
    logic [W-1:0]     mul_a_q;
    logic [W-1:0]     mul_b_q;

    logic             pick_any_s;
    logic [GNT_W-1:0] pick_idx_s;
    logic [W-1:0]     win_a_d;
    logic [W-1:0]     win_b_d;
    logic [GNT_W-1:0] ptr_d;
    logic [N-1:0]     ack_d;

    rr_pick #(.N(N)) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .any_o (pick_any_s),
        .idx_o (pick_idx_s)
    );

    // Winner operand select, next round-robin pointer and ack vector.
    always_comb begin
        win_a_d = bus.req_a[int'(pick_idx_s)*W +: W];
        win_b_d = bus.req_b[int'(pick_idx_s)*W +: W];
        ptr_d   = (gnt_q == GNT_W'(N - 1)) ? '0 : (gnt_q + GNT_W'(1));
        ack_d   = N'(onehot8(gnt_q));
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            mul_st_q   <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q      <= '0;
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b0;
                    if (pick_any_s) begin
                        state_q  <= ST_START;
                        gnt_q    <= pick_idx_s;
                        mul_a_q  <= win_a_d;
                        mul_b_q  <= win_b_d;
                        cnt_q    <= '0;
                        mul_st_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= ST_IDLE;
                        mul_st_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                // A done seen here is stale and deliberately not looked at.
                ST_START: begin
                    mul_st_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mul_done) begin
                        rsp_data_q <= bus.mul_result;
                        rsp_err_q  <= 1'b0;
                        ack_q      <= ack_d;
                        state_q    <= ST_RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        ack_q      <= ack_d;
                        state_q    <= ST_RESP;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    ack_q      <= '0;
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b0;
                    ptr_q      <= ptr_d;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ack_q    <= '0;
                    busy_q   <= 1'b0;
                    mul_st_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;
    assign bus.busy     = busy_q;
    assign bus.gnt_id   = gnt_q;
    assign bus.mul_st   = mul_st_q;
    assign bus.mul_a    = mul_a_q;
    assign bus.mul_b    = mul_b_q;

endmodule

// File: tb/tb_mult_sched.sv
// Randomised bench for mult_sched: clients, a latency-programmable multiplier
// model, and a scoreboard predicting grant order, product, error and timing.
module tb_mult_sched;
    import mult_sched_pkg::*;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mult_sched_if #(.N(N), .W(W)) bus ();

    mult_sched #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        job_act = 1'b0;
    int          job_win, job_st_cyc, job_delay;
    logic [15:0] job_data;
    logic        job_err;
    int          ref_ptr = 0;
    int          grant_log[$];
    int          jobs_done = 0;
    int          lat_cur = 0;
    int          lat_fix = 0;
    logic        rand_lat = 1'b0;
    logic        stuck_mode = 1'b0;
    int          spawn_total = 0;
    int          spawned = 0;
    int          post_seq = 0;
    int          post_done = 0;
    logic [N-1:0] post_mask = '0;
    logic [W-1:0] post_a[N];
    logic [W-1:0] post_b[N];

    function automatic logic [15:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return 16'(a) * 16'(b);
    endfunction

    function automatic int ref_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard and client side, evaluated just after each rising edge.
    initial begin : monitor
        logic         prev_st;
        int           w;
        logic [W-1:0] sa, sb;
        prev_st   = 1'b0;
        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                job_act = 1'b0;
                ref_ptr = 0;
                prev_st = 1'b0;
            end else begin
                if (bus.mul_st) begin
                    w = ref_pick(bus.req, ref_ptr);
                    grant_log.push_back(int'(bus.gnt_id));
                    check_eq("st_pulse_width", 32'(prev_st), 32'(0));
                    check_eq("gnt_id", 32'(bus.gnt_id), 32'(w));
                    check_eq("busy_on_start", 32'(bus.busy), 32'(1));
                    if (w >= 0) begin
                        sa = bus.req_a[w*W +: W];
                        sb = bus.req_b[w*W +: W];
                        check_eq("mul_a", 32'(bus.mul_a), 32'(sa));
                        check_eq("mul_b", 32'(bus.mul_b), 32'(sb));
                        lat_cur    = rand_lat ? int'($urandom_range(1, 20)) : lat_fix;
                        job_win    = w;
                        job_st_cyc = cyc;
                        job_act    = 1'b1;
                        if (stuck_mode) begin
                            job_delay = 2;
                            job_err   = 1'b0;
                            job_data  = prod(sa, sb);
                        end else if (lat_cur == 0 || lat_cur > TIMEOUT) begin
                            job_delay = TIMEOUT + 1;
                            job_err   = 1'b1;
                            job_data  = 16'd0;
                        end else begin
                            job_delay = lat_cur + 1;
                            job_err   = 1'b0;
                            job_data  = prod(sa, sb);
                        end
                        // The client is free to change operands once granted.
                        bus.req_a[w*W +: W] = W'($urandom);
                        bus.req_b[w*W +: W] = W'($urandom);
                    end
                end
                if (bus.ack != '0) begin
                    if (!job_act) begin
                        check_eq("ack_spurious", 32'(bus.ack), 32'(0));
                    end else begin
                        check_eq("ack_onehot", 32'(bus.ack), 32'(1) << job_win);
                        check_eq("rsp_data", 32'(bus.rsp_data), 32'(job_data));
                        check_eq("rsp_err", 32'(bus.rsp_err), 32'(job_err));
                        check_eq("ack_latency", 32'(cyc - job_st_cyc), 32'(job_delay));
                        check_eq("busy_on_ack", 32'(bus.busy), 32'(1));
                        ref_ptr = (job_win + 1) % N;
                        job_act = 1'b0;
                        jobs_done++;
                        if (spawned < spawn_total) begin
                            spawned++;
                            bus.req_a[job_win*W +: W] = W'($urandom);
                            bus.req_b[job_win*W +: W] = W'($urandom);
                        end else begin
                            bus.req[job_win] = 1'b0;
                        end
                    end
                end else if (job_act && (cyc - job_st_cyc) > job_delay) begin
                    check_eq("ack_overdue", 32'(bus.ack), 32'(1) << job_win);
                    job_act = 1'b0;
                end
                prev_st = bus.mul_st;
            end
            if (post_seq != post_done) begin
                for (int i = 0; i < N; i++) begin
                    if (post_mask[i]) begin
                        bus.req_a[i*W +: W] = post_a[i];
                        bus.req_b[i*W +: W] = post_b[i];
                        bus.req[i]          = 1'b1;
                    end
                end
                post_done = post_seq;
            end
        end
    end

    // Multiplier model: done after lat_cur cycles (0 = never), or stuck high.
    initial begin : mul_model
        int remaining;
        remaining      = 0;
        bus.mul_done   = 1'b0;
        bus.mul_result = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                remaining      = 0;
                bus.mul_done   = 1'b0;
                bus.mul_result = '0;
            end else if (stuck_mode) begin
                bus.mul_done   = 1'b1;
                bus.mul_result = bus.mul_st ? 16'hDEAD : prod(bus.mul_a, bus.mul_b);
            end else begin
                bus.mul_done   = 1'b0;
                bus.mul_result = 16'hBEEF;
                if (bus.mul_st) begin
                    remaining = lat_cur;
                end else if (remaining > 0) begin
                    remaining--;
                    if (remaining == 0) begin
                        bus.mul_done   = 1'b1;
                        bus.mul_result = prod(bus.mul_a, bus.mul_b);
                    end
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check_eq({tag, "_ack"}, 32'(bus.ack), 32'(0));
        check_eq({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(0));
        check_eq({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(0));
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'(0));
        check_eq({tag, "_gnt_id"}, 32'(bus.gnt_id), 32'(0));
        check_eq({tag, "_mul_st"}, 32'(bus.mul_st), 32'(0));
        check_eq({tag, "_mul_a"}, 32'(bus.mul_a), 32'(0));
        check_eq({tag, "_mul_b"}, 32'(bus.mul_b), 32'(0));
    endtask

    task automatic post(input logic [N-1:0] m);
        int n;
        post_mask = m;
        post_seq++;
        n = 0;
        while (post_done != post_seq && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (post_done != post_seq) check_eq("post_applied", 32'(post_done), 32'(post_seq));
    endtask

    task automatic wait_jobs(input int target, input int budget);
        int n;
        n = 0;
        while (jobs_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (jobs_done < target) check_eq("wait_jobs", 32'(jobs_done), 32'(target));
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            post_a[i] = W'($urandom);
            post_b[i] = W'($urandom);
        end
    endtask

    initial begin : stim
        int          base;
        int          cnt[N];
        int          n;
        logic [N-1:0] m;

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Client 1 alone, 3*3 with a 9-cycle multiplier.
        lat_fix = 9;
        post_a[1] = 8'd3; post_b[1] = 8'd3;
        base = grant_log.size();
        post(4'b0010);
        wait_jobs(jobs_done + 1, 100);
        if (grant_log.size() > base) check_eq("single_client", 32'(grant_log[base]), 32'(1));

        // Clients 0 and 2 from reset, then both again.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        lat_fix = 6;
        post_a[0] = 8'd255; post_b[0] = 8'd255;
        post_a[2] = 8'd12;  post_b[2] = 8'd10;
        base = grant_log.size();
        post(4'b0101);
        wait_jobs(jobs_done + 2, 100);
        rand_ops();
        post(4'b0101);
        wait_jobs(jobs_done + 2, 100);
        if (grant_log.size() >= base + 4) begin
            check_eq("pair_0", 32'(grant_log[base]),     32'(0));
            check_eq("pair_1", 32'(grant_log[base + 1]), 32'(2));
            check_eq("pair_2", 32'(grant_log[base + 2]), 32'(0));
            check_eq("pair_3", 32'(grant_log[base + 3]), 32'(2));
        end

        // All four requesting continuously for eight jobs.
        rand_lat = 1'b1;
        rand_ops();
        spawn_total = spawn_total + 4;
        base = grant_log.size();
        post(4'b1111);
        wait_jobs(jobs_done + 8, 400);
        rand_lat = 1'b0;
        if (grant_log.size() >= base + 8) begin
            for (int i = 0; i < N; i++) cnt[i] = 0;
            for (int k = 0; k < 8; k++) cnt[grant_log[base + k] % N]++;
            for (int k = 1; k < 8; k++)
                check_eq("fair_order", 32'(grant_log[base + k]), 32'((grant_log[base + k - 1] + 1) % N));
            for (int i = 0; i < N; i++) check_eq("fair_count", 32'(cnt[i]), 32'(2));
        end

        // Watchdog: never done, done exactly at the limit, done one too late.
        rand_ops();
        lat_fix = 0;  post(4'b0100); wait_jobs(jobs_done + 1, 200);
        lat_fix = 64; post(4'b0010); wait_jobs(jobs_done + 1, 200);
        lat_fix = 65; post(4'b0001); wait_jobs(jobs_done + 1, 200);
        lat_fix = 5;  post(4'b1000); wait_jobs(jobs_done + 1, 100);

        // Done held high across START.
        stuck_mode = 1'b1;
        rand_ops();
        post(4'b1000);
        wait_jobs(jobs_done + 1, 100);
        stuck_mode = 1'b0;

        // Reset in the middle of a wait; pending requests restart from 0.
        lat_fix = 3;
        rand_ops();
        post(4'b0010);
        wait_jobs(jobs_done + 1, 100);
        lat_fix = 30;
        post(4'b1001);
        n = 0;
        while (!job_act && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("midrst_job_started", 32'(job_act), 32'(1));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n   = 1'b1;
        lat_fix = 4;
        base    = grant_log.size();
        wait_jobs(jobs_done + 2, 100);
        if (grant_log.size() >= base + 2) begin
            check_eq("midrst_first",  32'(grant_log[base]),     32'(0));
            check_eq("midrst_second", 32'(grant_log[base + 1]), 32'(3));
        end

        // Random bursts of requesters with random latencies.
        rand_lat = 1'b1;
        for (int r = 0; r < 6; r++) begin
            m = N'($urandom_range(1, 15));
            rand_ops();
            post(m);
            wait_jobs(jobs_done + $countones(m), 600);
        end
        rand_lat = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("end_busy", 32'(bus.busy), 32'(0));
        check_eq("end_ack", 32'(bus.ack), 32'(0));
        check_eq("end_mul_st", 32'(bus.mul_st), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
